// File: rtl/muldiv_sequencer_pkg.sv
// Shared ALU control op-codes and the multiply/divide sequencer state encoding.
package muldiv_sequencer_pkg;

    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_DIV = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the core and the multiply/divide sequencer.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);

    logic             Start;
    logic [3:0]       ALU_Control;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic             DivByZero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, ALU_Control, A, B,
        input  Busy, Done, DivByZero, HI, LO
    );

    modport slave (
        input  Start, ALU_Control, A, B,
        output Busy, Done, DivByZero, HI, LO
    );

endinterface

// File: rtl/muldiv_sequencer_step.sv
// One iteration of shift-add multiply or restoring divide on unsigned magnitudes.
// Multiply: acc/quot form the 2W accumulator {upper, lower}; the lower half
// starts as the multiplier and is consumed LSB first as the product shifts in.
// Divide: acc is the partial remainder, quot the dividend/quotient register.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] quot_in,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] quot_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Compute both candidate iterations and select by mode.
    always_comb begin
        sum      = {1'b0, acc_in} + (quot_in[0] ? {1'b0, opnd} : '0);
        shifted  = {acc_in, quot_in[WIDTH-1]};
        diff     = shifted - {1'b0, opnd};
        acc_out  = sum[WIDTH:1];
        quot_out = {sum[0], quot_in[WIDTH-1:1]};
        if (div_mode) begin
            if (!diff[WIDTH]) begin
                acc_out  = diff[WIDTH-1:0];
                quot_out = {quot_in[WIDTH-2:0], 1'b1};
            end else begin
                acc_out  = shifted[WIDTH-1:0];
                quot_out = {quot_in[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply/divide controller writing the HI/LO registers.
import muldiv_sequencer_pkg::*;

module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_sequencer_if.slave bus
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc, quot, opnd;
    logic [WIDTH-1:0]   acc_nxt, quot_nxt;
    logic               sa, sb, is_div;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               done_r, dbz_r;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_neg;
    logic               start_mul, start_div, start_dbz;

    assign abs_a     = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign abs_b     = bus.B[WIDTH-1] ? -bus.B : bus.B;
    assign start_mul = bus.Start && (bus.ALU_Control == OP_MUL);
    assign start_div = bus.Start && (bus.ALU_Control == OP_DIV) && (bus.B != '0);
    assign start_dbz = bus.Start && (bus.ALU_Control == OP_DIV) && (bus.B == '0);
    assign prod_neg  = -{acc, quot};

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (is_div),
        .acc_in   (acc),
        .quot_in  (quot),
        .opnd     (opnd),
        .acc_out  (acc_nxt),
        .quot_out (quot_nxt)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: accept requests only in IDLE, run WIDTH iterations, then fix signs.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_mul)      state_nxt = MUL;
                else if (start_div) state_nxt = DIV;
            end
            MUL, DIV: if (cnt == LAST) state_nxt = FIX;
            FIX:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, sign correction and result/pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            quot   <= '0;
            opnd   <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            is_div <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_mul || start_div) begin
                        // Multiply keeps the multiplier in the lower accumulator half.
                        acc    <= '0;
                        quot   <= start_div ? abs_a : abs_b;
                        opnd   <= start_div ? abs_b : abs_a;
                        sa     <= bus.A[WIDTH-1];
                        sb     <= bus.B[WIDTH-1];
                        is_div <= start_div;
                        cnt    <= '0;
                    end else if (start_dbz) begin
                        done_r <= 1'b1;
                        dbz_r  <= 1'b1;
                    end
                end
                MUL, DIV: begin
                    acc  <= acc_nxt;
                    quot <= quot_nxt;
                    cnt  <= cnt + 1'b1;
                end
                FIX: begin
                    if (is_div) begin
                        lo_r <= (sa ^ sb) ? -quot : quot;
                        hi_r <= sa ? -acc : acc;
                    end else if (sa ^ sb) begin
                        {hi_r, lo_r} <= prod_neg;
                    end else begin
                        {hi_r, lo_r} <= {acc, quot};
                    end
                    done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy      = (state != IDLE);
    assign bus.Done      = done_r;
    assign bus.DivByZero = dbz_r;
    assign bus.HI        = hi_r;
    assign bus.LO        = lo_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
import muldiv_sequencer_pkg::*;

module tb_muldiv_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Drive a request for one edge; returns 1 time unit after the sampling edge.
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.ALU_Control = op;
        bus.A = a;
        bus.B = b;
        @(posedge clk); #1;
        bus.Start = 1'b0;
    endtask

    // Count edges until Done, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!bus.Done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.Start = 1'b0;
        bus.ALU_Control = 4'b0000;
        bus.A = '0;
        bus.B = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
        n_cmp++; if (bus.Done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.Done); end
        n_cmp++; if (bus.DivByZero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b expected 0", bus.DivByZero); end
        n_cmp++; if (bus.HI !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h expected 0", bus.HI); end
        n_cmp++; if (bus.LO !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h expected 0", bus.LO); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_basic;
        int cyc;
        launch(OP_MUL, 32'd7, 32'd6);
        n_cmp++; if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL mul_busy_rise: got %b expected 1", bus.Busy); end
        wait_done(cyc);
        n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL mul_latency: got %0d expected 33", cyc); end
        n_cmp++; if (bus.HI !== 32'h0) begin n_err++; $display("FAIL mul_7x6_hi: got %h expected 00000000", bus.HI); end
        n_cmp++; if (bus.LO !== 32'h2A) begin n_err++; $display("FAIL mul_7x6_lo: got %h expected 0000002a", bus.LO); end
        n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL mul_busy_at_done: got %b expected 0", bus.Busy); end
        n_cmp++; if (bus.DivByZero !== 1'b0) begin n_err++; $display("FAIL mul_dbz: got %b expected 0", bus.DivByZero); end
        @(posedge clk); #1;
        n_cmp++; if (bus.Done !== 1'b0) begin n_err++; $display("FAIL mul_done_pulse: got %b expected 0", bus.Done); end
        n_cmp++; if (bus.LO !== 32'h2A) begin n_err++; $display("FAIL mul_lo_hold: got %h expected 0000002a", bus.LO); end
    endtask

    task automatic test_mul_signed;
        int cyc;
        launch(OP_MUL, 32'hFFFFFFFD, 32'd5);
        wait_done(cyc);
        n_cmp++; if (bus.HI !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mul_neg3x5_hi: got %h expected ffffffff", bus.HI); end
        n_cmp++; if (bus.LO !== 32'hFFFFFFF1) begin n_err++; $display("FAIL mul_neg3x5_lo: got %h expected fffffff1", bus.LO); end
        @(posedge clk); #1;
        launch(OP_MUL, 32'h7FFFFFFF, 32'h7FFFFFFF);
        wait_done(cyc);
        n_cmp++; if (bus.HI !== 32'h3FFFFFFF) begin n_err++; $display("FAIL mul_max_hi: got %h expected 3fffffff", bus.HI); end
        n_cmp++; if (bus.LO !== 32'h00000001) begin n_err++; $display("FAIL mul_max_lo: got %h expected 00000001", bus.LO); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_signed;
        int cyc;
        launch(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(cyc);
        n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL div_latency: got %0d expected 33", cyc); end
        n_cmp++; if (bus.LO !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_neg7by2_lo: got %h expected fffffffd", bus.LO); end
        n_cmp++; if (bus.HI !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_neg7by2_hi: got %h expected ffffffff", bus.HI); end
        @(posedge clk); #1;
        launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(cyc);
        n_cmp++; if (bus.LO !== 32'h80000000) begin n_err++; $display("FAIL div_ovf_lo: got %h expected 80000000", bus.LO); end
        n_cmp++; if (bus.HI !== 32'h0) begin n_err++; $display("FAIL div_ovf_hi: got %h expected 00000000", bus.HI); end
        n_cmp++; if (bus.DivByZero !== 1'b0) begin n_err++; $display("FAIL div_ovf_dbz: got %b expected 0", bus.DivByZero); end
        @(posedge clk); #1;
        launch(OP_DIV, 32'd100, 32'hFFFFFFF9);
        wait_done(cyc);
        n_cmp++; if (bus.LO !== 32'hFFFFFFF2) begin n_err++; $display("FAIL div_100byneg7_lo: got %h expected fffffff2", bus.LO); end
        n_cmp++; if (bus.HI !== 32'h00000002) begin n_err++; $display("FAIL div_100byneg7_hi: got %h expected 00000002", bus.HI); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_by_zero;
        int cyc;
        // 0x66666666 * 0x2AAAAAAB = 0x11111111_22222222
        launch(OP_MUL, 32'h66666666, 32'h2AAAAAAB);
        wait_done(cyc);
        n_cmp++; if (bus.HI !== 32'h11111111) begin n_err++; $display("FAIL dbz_setup_hi: got %h expected 11111111", bus.HI); end
        n_cmp++; if (bus.LO !== 32'h22222222) begin n_err++; $display("FAIL dbz_setup_lo: got %h expected 22222222", bus.LO); end
        @(posedge clk); #1;
        launch(OP_DIV, 32'd5, 32'd0);
        n_cmp++; if (bus.Done !== 1'b1) begin n_err++; $display("FAIL dbz_done: got %b expected 1", bus.Done); end
        n_cmp++; if (bus.DivByZero !== 1'b1) begin n_err++; $display("FAIL dbz_flag: got %b expected 1", bus.DivByZero); end
        n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL dbz_busy: got %b expected 0", bus.Busy); end
        n_cmp++; if (bus.HI !== 32'h11111111) begin n_err++; $display("FAIL dbz_hi_hold: got %h expected 11111111", bus.HI); end
        n_cmp++; if (bus.LO !== 32'h22222222) begin n_err++; $display("FAIL dbz_lo_hold: got %h expected 22222222", bus.LO); end
        @(posedge clk); #1;
        n_cmp++; if (bus.Done !== 1'b0) begin n_err++; $display("FAIL dbz_done_pulse: got %b expected 0", bus.Done); end
        n_cmp++; if (bus.DivByZero !== 1'b0) begin n_err++; $display("FAIL dbz_flag_pulse: got %b expected 0", bus.DivByZero); end
        n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL dbz_busy_after: got %b expected 0", bus.Busy); end
    endtask

    task automatic test_ignored_op;
        launch(4'b0000, 32'd9, 32'd9);
        n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL ign_busy: got %b expected 0", bus.Busy); end
        n_cmp++; if (bus.Done !== 1'b0) begin n_err++; $display("FAIL ign_done: got %b expected 0", bus.Done); end
        n_cmp++; if (bus.LO !== 32'h22222222) begin n_err++; $display("FAIL ign_lo_hold: got %h expected 22222222", bus.LO); end
    endtask

    task automatic test_start_while_busy;
        int cyc;
        launch(OP_MUL, 32'd7, 32'd6);
        repeat (9) begin @(posedge clk); #1; end
        launch(OP_MUL, 32'd3, 32'd3);
        wait_done(cyc);
        n_cmp++; if (cyc + 10 !== 33) begin n_err++; $display("FAIL busy_start_latency: got %0d expected 33", cyc + 10); end
        n_cmp++; if (bus.LO !== 32'h2A) begin n_err++; $display("FAIL busy_start_lo: got %h expected 0000002a", bus.LO); end
        n_cmp++; if (bus.HI !== 32'h0) begin n_err++; $display("FAIL busy_start_hi: got %h expected 00000000", bus.HI); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        // Caller leaves us in the Done cycle of the previous operation.
        launch(OP_DIV, 32'd100, 32'hFFFFFFF9);
        n_cmp++; if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b expected 1", bus.Busy); end
        wait_done(cyc);
        n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL b2b_latency: got %0d expected 33", cyc); end
        n_cmp++; if (bus.LO !== 32'hFFFFFFF2) begin n_err++; $display("FAIL b2b_lo: got %h expected fffffff2", bus.LO); end
        n_cmp++; if (bus.HI !== 32'h00000002) begin n_err++; $display("FAIL b2b_hi: got %h expected 00000002", bus.HI); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_div;
        int cyc;
        launch(OP_DIV, 32'd1000, 32'd7);
        repeat (15) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b expected 0", bus.Busy); end
        n_cmp++; if (bus.Done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done: got %b expected 0", bus.Done); end
        n_cmp++; if (bus.HI !== 32'h0) begin n_err++; $display("FAIL rst_mid_hi: got %h expected 00000000", bus.HI); end
        n_cmp++; if (bus.LO !== 32'h0) begin n_err++; $display("FAIL rst_mid_lo: got %h expected 00000000", bus.LO); end
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        launch(OP_DIV, 32'd9, 32'd3);
        wait_done(cyc);
        n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL rst_div_latency: got %0d expected 33", cyc); end
        n_cmp++; if (bus.LO !== 32'd3) begin n_err++; $display("FAIL rst_div_lo: got %h expected 00000003", bus.LO); end
        n_cmp++; if (bus.HI !== 32'd0) begin n_err++; $display("FAIL rst_div_hi: got %h expected 00000000", bus.HI); end
    endtask

    initial begin
        test_reset;
        test_mul_basic;
        test_mul_signed;
        test_div_signed;
        test_div_by_zero;
        test_ignored_op;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid_div;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle controller and iterative datapath for the multiply (ALU_Control 4'b0101) and divide (ALU_Control 4'b1011) operations decoded by the ALU control logic.
- Accepts a start request and sequences a 32-step shift-add multiply or restoring divide on signed operands.
- Writes results to the HI/LO registers.
- Holds Busy high so the core stalls instruction fetch and register writeback until the operation completes.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.
OP_MUL, 4'b0101, ALU_Control code that selects multiply.
OP_DIV, 4'b1011, ALU_Control code that selects divide.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
Start  input  1  request; sampled only in IDLE.
ALU_Control  input  4  operation select; sampled with Start.
A  input  WIDTH  dividend or multiplicand (rs), two's complement.
B  input  WIDTH  divisor or multiplier (rt), two's complement.
Busy  output  1  operation in flight; the core stalls while high.
Done  output  1  one-cycle pulse; HI/LO are valid in the same cycle.
DivByZero  output  1  one-cycle pulse with Done when a divide had B==0.
HI  output  WIDTH  product upper half, or remainder.
LO  output  WIDTH  product lower half, or quotient.

Behaviour:
- Reset: the block may be reset at any time, including mid-operation. The state returns to IDLE, all internal registers clear, and Busy, Done, DivByZero, HI and LO all go to 0.
- States: IDLE, MUL, DIV, FIX.
- IDLE, Start=1, ALU_Control==OP_MUL:
  - Latch |A| and |B|, plus sign flags sa = A[W-1] and sb = B[W-1].
  - Clear the 2W accumulator and set count = 0.
  - Go to MUL.
- IDLE, Start=1, ALU_Control==OP_DIV, B!=0: same latching as MUL (restoring divider: partial remainder = 0, quotient register = |A|), then go to DIV.
- IDLE, Start=1, ALU_Control==OP_DIV, B==0: no iteration. On the next edge Done=1 and DivByZero=1 for one cycle. HI/LO are unchanged and the state stays IDLE.
- IDLE, Start=1, any other ALU_Control: ignored, no response.
- MUL / DIV: one iteration per cycle while count runs 0..W-1; count is $clog2(W) bits wide. On the edge where count==W-1, go to FIX.
  - MUL step: if the multiplier LSB is 1, add the multiplicand to the upper half of the accumulator (W+1-bit add). Then shift right by 1.
  - DIV step: shift {rem, quot} left by 1, then trial-subtract |B| from rem. If the result is non-negative, commit it and set quot[0]=1; otherwise restore.
- FIX (one cycle): sign correction, then write HI/LO, raise Done, return to IDLE.
  - MUL: {HI,LO} = (sa^sb) ? -acc : acc, over 2W bits.
  - DIV: LO = (sa^sb) ? -quot : quot; HI = sa ? -rem : rem.
  - Overflow case -2^(W-1) / -1: the natural W-bit wrap applies, giving LO = 0x80000000 and HI = 0. No flag is raised.
- Latency: for Start sampled at edge E, Busy=1 after E. Busy=0 and Done=1 after edge E+W+1 (33 for W=32). Done lasts exactly one cycle.
- Busy is high in MUL, DIV and FIX, and low in IDLE, including the Done cycle.
- Start while Busy: ignored. The in-flight operation and its operands are unaffected.
- Start in the Done cycle: accepted, because the state is IDLE. The new Busy rises on the following edge.
- HI/LO hold their values between operations and change only in FIX.
- Outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- Shared package / include (alu_defs): ALU_Control op-code constants, including OP_MUL and OP_DIV, so they are common with the ALU control decoder; state encoding localparams (IDLE=2'd0, MUL=2'd1, DIV=2'd2, FIX=2'd3).
- Sub-module: muldiv_step. It is combinational and computes one iteration for either mode: inputs are mode, accumulator/remainder, quotient and operand; outputs are the next accumulator/remainder and quotient. The sequencer holds the FSM, counter, sign flags and the FIX negation.

Test Plan:
- Multiply 7 × 6: Start with OP_MUL → Busy for 33 cycles, then Done one cycle with HI=0x00000000, LO=0x0000002A.
- Signed multiply -3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; separately 0x7FFFFFFF × 0x7FFFFFFF → HI=0x3FFFFFFF, LO=0x00000001.
- Signed divide -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, with DivByZero=0.
- Divide by zero, starting from HI/LO=0x11111111/0x22222222 with A=5, B=0 → Done and DivByZero pulse on the next edge, HI/LO unchanged, Busy never asserted.
- Start with OP_MUL on operands 3 × 3 at cycle 10 of a 7 × 6 operation → ignored; Done still arrives at the original cycle with LO=0x2A.
- Reset asserted asynchronously mid-DIV at iteration 15 → Busy, Done, HI and LO read 0 immediately. After release, a new 9 / 3 yields LO=3, HI=0.
